mem_stage_sram_ctrl: RTL and testbench
======================================

# mem_stage_sram_ctrl

Memory-access stage of the ARM pipeline. It sits between the EXE stage register and the MEM stage register and performs data loads and stores to an external 16-bit SRAM as two half-word accesses. While an access is in progress it deasserts `ready` so that hazard/freeze logic stalls all upstream stage registers. It produces `Mem_read_value`, which the MEM stage register captures in the cycle `ready` returns high.

## Interface
Parameters:
- `BIT_NUMBER`, 32: pipeline data width. Fixed at 32 for this block.
- `ADDR_OFFSET`, 1024: byte address of SRAM word 0 in the CPU map.
- `WAIT_CYCLES`, 2: cycles per half-word SRAM access. Legal range is ≥1.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset; asynchronous, active-low
- `Mem_R_en`  in  1  load request from EXE stage register
- `Mem_W_en`  in  1  store request from EXE stage register
- `ALU_result`  in  32  byte address
- `Val_Rm`  in  32  store data
- `Mem_read_value`  out  32  registered load data
- `ready`  out  1  high = stage may advance; low = freeze pipeline
- `SRAM_ADDR`  out  18  half-word address
- `SRAM_DQ_out`  out  16  write data to pad driver
- `SRAM_DQ_in`  in  16  read data from pad
- `SRAM_DQ_oe`  out  1  pad output enable
- `SRAM_WE_N`  out  1  SRAM write enable, active-low

## Operation
- FSM states: IDLE, LOW, HIGH, DONE. A counter `cnt` (width ≥ clog2(WAIT_CYCLES)) supports the wait cycles.
- **IDLE**
  - `ready = ~(Mem_R_en | Mem_W_en)` (combinational).
  - On a request: latch `is_write = Mem_W_en`, word index `w = (ALU_result - ADDR_OFFSET)[18:2]` (mod 2^32, truncated to 17 bits), and `Val_Rm`; set `cnt = 0`; go to LOW.
- **LOW**
  - `SRAM_ADDR = {w,1'b0}`.
  - On a write: `SRAM_DQ_out = data[15:0]`, `SRAM_DQ_oe = 1`, `SRAM_WE_N = 0` for all cycles of the phase.
  - On a read: `SRAM_DQ_oe = 0`, `SRAM_WE_N = 1`; when `cnt == WAIT_CYCLES-1`, sample `SRAM_DQ_in` into `Mem_read_value[15:0]`.
  - When `cnt == WAIT_CYCLES-1`: clear `cnt` and go to HIGH. Otherwise increment `cnt`.
- **HIGH**
  - Same as LOW, with `SRAM_ADDR = {w,1'b1}`, `data[31:16]`, and `Mem_read_value[31:16]`.
  - Go to DONE at the end of the phase.
- **DONE**
  - `ready = 1` for exactly one cycle, regardless of the request inputs. The same frozen instruction is still present on the inputs, and it must not retrigger an access.
  - Next state is IDLE.
- ready in the active states: `ready = 0` in LOW and HIGH.
- SRAM outputs outside LOW and HIGH: `SRAM_ADDR = 0`, `SRAM_DQ_out = 0`, `SRAM_DQ_oe = 0`, `SRAM_WE_N = 1`.
- Both enables asserted: treat the request as a store. The store takes priority.
- Input changes after IDLE are ignored, because the address and data are latched.
- `Mem_read_value` changes only on read-phase samples. A store does not change it.

## Timing
- Reset values (with `rst` low, taking effect immediately and asynchronously):
  - state = IDLE, `cnt = 0`, latches = 0, `Mem_read_value = 0`.
  - `SRAM_WE_N = 1`, `SRAM_DQ_oe = 0`, `SRAM_ADDR = 0`, `SRAM_DQ_out = 0`.
  - `ready = ~(Mem_R_en | Mem_W_en)`.
- Access latency, with the request first seen in cycle 0 (IDLE):
  - LOW occupies cycles 1..W; HIGH occupies cycles W+1..2W; DONE is cycle 2W+1.
  - `ready` is low for 2W+1 cycles.
  - With W=2: `ready` is low in cycles 0–4 and high in cycle 5.
- Load data is valid in `Mem_read_value` from the start of DONE. The MEM stage register captures it at the DONE→IDLE edge.
- Reset in the middle of an access aborts the access.
  - `SRAM_WE_N` rises asynchronously.
  - A half-completed store leaves the SRAM partially written. This is acceptable.
- Back-to-back accesses: a new request seen in the IDLE cycle after DONE starts immediately. There is no idle cycle on the SRAM pins beyond the IDLE cycle itself.

## Test plan
- **No request:** `Mem_R_en = Mem_W_en = 0` for 10 cycles → `ready = 1`, `SRAM_WE_N = 1`, `SRAM_DQ_oe = 0`, state stays IDLE.
- **Store, W=2:** `Mem_W_en = 1`, `ALU_result = 1032`, `Val_Rm = 0xDEADBEEF` → SRAM addr 4 written with 0xBEEF during cycles 1–2, addr 5 written with 0xDEAD during cycles 3–4; `ready` is low in cycles 0–4 and high in cycle 5; `Mem_read_value` is unchanged.
- **Load back:** `Mem_R_en = 1`, `ALU_result = 1032`, SRAM model returns the stored halves → `Mem_read_value = 0xDEADBEEF` in cycle 5; `SRAM_DQ_oe = 0` throughout.
- **Simultaneous enables:** `Mem_R_en = Mem_W_en = 1`, `Val_Rm = 0x12345678` → a store is performed; SRAM addr pair holds 0x5678 / 0x1234.
- **Address boundary:**
  - `ALU_result = 1024 + 4*131071` → `SRAM_ADDR` is 0x3FFFE, then 0x3FFFF.
  - `ALU_result = 1024 + 4*131072` → `SRAM_ADDR` wraps to 0x00000, then 0x00001.
- **Reset mid-store:** assert `rst` low in cycle 3 of a store → `SRAM_WE_N` is 1 and `SRAM_DQ_oe` is 0 in the same cycle, without waiting for a clock edge; after release with no request, `ready = 1`, `Mem_read_value = 0`, and the next load runs a full 2W+1 stall.

Source files
------------

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage SRAM controller: splits each 32-bit load/store into two 16-bit SRAM
// accesses and holds ready low so the upstream pipeline freezes until it completes.
module mem_stage_sram_ctrl #(
   parameter int unsigned BIT_NUMBER  = 32,
   parameter int unsigned ADDR_OFFSET = 1024,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  Mem_R_en,
   input  logic                  Mem_W_en,
   input  logic [BIT_NUMBER-1:0] ALU_result,
   input  logic [BIT_NUMBER-1:0] Val_Rm,
   output logic [BIT_NUMBER-1:0] Mem_read_value,
   output logic                  ready,
   output logic [17:0]           SRAM_ADDR,
   output logic [15:0]           SRAM_DQ_out,
   input  logic [15:0]           SRAM_DQ_in,
   output logic                  SRAM_DQ_oe,
   output logic                  SRAM_WE_N
);

   localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

   state_e                state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  is_write_q, is_write_d;
   logic [16:0]           word_q, word_d;
   logic [BIT_NUMBER-1:0] data_q, data_d;
   logic [BIT_NUMBER-1:0] rdata_q, rdata_d;

   logic [BIT_NUMBER-1:0] addr_off;
   logic                  phase_last;
   logic                  unused_addr;

   // Byte offset into the SRAM window; only the word-index bits are kept.
   assign addr_off    = ALU_result - BIT_NUMBER'(ADDR_OFFSET);
   assign unused_addr = ^{addr_off[BIT_NUMBER-1:19], addr_off[1:0]};
   assign phase_last  = (cnt_q == CntLast);

   assign Mem_read_value = rdata_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      is_write_d  = is_write_q;
      word_d      = word_q;
      data_d      = data_q;
      rdata_d     = rdata_q;
      ready       = 1'b0;
      SRAM_ADDR   = '0;
      SRAM_DQ_out = '0;
      SRAM_DQ_oe  = 1'b0;
      SRAM_WE_N   = 1'b1;

      unique case (state_q)
         StIdle: begin
            ready = ~(Mem_R_en | Mem_W_en);
            if (Mem_R_en | Mem_W_en) begin
               is_write_d = Mem_W_en;
               word_d     = addr_off[18:2];
               data_d     = Val_Rm;
               cnt_d      = '0;
               state_d    = StLow;
            end
         end
         StLow: begin
            SRAM_ADDR = {word_q, 1'b0};
            if (is_write_q) begin
               SRAM_DQ_out = data_q[15:0];
               SRAM_DQ_oe  = 1'b1;
               SRAM_WE_N   = 1'b0;
            end
            if (phase_last) begin
               if (!is_write_q) rdata_d[15:0] = SRAM_DQ_in;
               cnt_d   = '0;
               state_d = StHigh;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StHigh: begin
            SRAM_ADDR = {word_q, 1'b1};
            if (is_write_q) begin
               SRAM_DQ_out = data_q[BIT_NUMBER-1:16];
               SRAM_DQ_oe  = 1'b1;
               SRAM_WE_N   = 1'b0;
            end
            if (phase_last) begin
               if (!is_write_q) rdata_d[BIT_NUMBER-1:16] = SRAM_DQ_in;
               cnt_d   = '0;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StDone: begin
            // The frozen request is still on the inputs here; do not restart.
            ready   = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         is_write_q <= 1'b0;
         word_q     <= '0;
         data_q     <= '0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         is_write_q <= is_write_d;
         word_q     <= word_d;
         data_q     <= data_d;
         rdata_q    <= rdata_d;
      end
   end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: table of load/store vectors against an SRAM model,
// with a scoreboard of expected load values and hand sequences for reset cases.
module tb_mem_stage_sram_ctrl;

   localparam int unsigned W = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        Mem_R_en, Mem_W_en;
   logic [31:0] ALU_result, Val_Rm;
   logic [31:0] Mem_read_value;
   logic        ready;
   logic [17:0] SRAM_ADDR;
   logic [15:0] SRAM_DQ_out, SRAM_DQ_in;
   logic        SRAM_DQ_oe, SRAM_WE_N;

   int total = 0;
   int bad   = 0;

   logic [15:0] mem [0:262143];
   logic [31:0] sb_q [$];

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [17:0] wa;
      logic [31:0] rv;
   } vec_t;

   vec_t vecs [11];

   mem_stage_sram_ctrl #(
      .BIT_NUMBER (32),
      .ADDR_OFFSET(1024),
      .WAIT_CYCLES(W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .Mem_R_en      (Mem_R_en),
      .Mem_W_en      (Mem_W_en),
      .ALU_result    (ALU_result),
      .Val_Rm        (Val_Rm),
      .Mem_read_value(Mem_read_value),
      .ready         (ready),
      .SRAM_ADDR     (SRAM_ADDR),
      .SRAM_DQ_out   (SRAM_DQ_out),
      .SRAM_DQ_in    (SRAM_DQ_in),
      .SRAM_DQ_oe    (SRAM_DQ_oe),
      .SRAM_WE_N     (SRAM_WE_N)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (!SRAM_WE_N) mem[SRAM_ADDR] <= SRAM_DQ_out;
   assign SRAM_DQ_in = mem[SRAM_ADDR];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Entered and left #1 after a rising edge.
   task automatic idle(input int n);
      Mem_R_en = 1'b0;
      Mem_W_en = 1'b0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         chk("idle_ready", 32'(ready), 32'd1);
         chk("idle_we_n", 32'(SRAM_WE_N), 32'd1);
         chk("idle_oe", 32'(SRAM_DQ_oe), 32'd0);
         @(posedge clk); #1;
      end
   endtask

   task automatic access(input vec_t v);
      logic [31:0] exp_rv;
      Mem_R_en   = v.rd;
      Mem_W_en   = v.wr;
      ALU_result = v.addr;
      Val_Rm     = v.data;
      sb_q.push_back(v.rv);
      for (int cyc = 0; cyc <= 2 * W + 1; cyc++) begin
         @(negedge clk);
         chk($sformatf("ready_c%0d", cyc), 32'(ready), (cyc == 2 * W + 1) ? 32'd1 : 32'd0);
         if (cyc >= 1 && cyc <= 2 * W) begin
            chk($sformatf("addr_c%0d", cyc), 32'(SRAM_ADDR),
                32'(v.wa | ((cyc > W) ? 18'd1 : 18'd0)));
            chk($sformatf("we_n_c%0d", cyc), 32'(SRAM_WE_N), 32'(!v.wr));
            chk($sformatf("oe_c%0d", cyc), 32'(SRAM_DQ_oe), 32'(v.wr));
            if (v.wr)
               chk($sformatf("dq_c%0d", cyc), 32'(SRAM_DQ_out),
                   (cyc > W) ? 32'(v.data[31:16]) : 32'(v.data[15:0]));
         end else begin
            chk($sformatf("we_n_c%0d", cyc), 32'(SRAM_WE_N), 32'd1);
            chk($sformatf("oe_c%0d", cyc), 32'(SRAM_DQ_oe), 32'd0);
         end
         if (cyc == 2 * W + 1) begin
            if (sb_q.size() == 0) begin
               chk("sb_empty", 32'd1, 32'd0);
            end else begin
               exp_rv = sb_q.pop_front();
               chk("rd_value", Mem_read_value, exp_rv);
            end
         end
         // Latched request must not see later input changes.
         if (cyc >= 1 && cyc < 2 * W) begin
            ALU_result = $urandom;
            Val_Rm     = $urandom;
         end else if (cyc == 2 * W) begin
            ALU_result = v.addr;
            Val_Rm     = v.data;
         end
         @(posedge clk); #1;
      end
      if (v.wr) begin
         chk("mem_lo", 32'(mem[v.wa]), 32'(v.data[15:0]));
         chk("mem_hi", 32'(mem[v.wa | 18'd1]), 32'(v.data[31:16]));
      end
   endtask

   initial begin
      vec_t rv_vec;
      vecs[0]  = '{1'b0, 1'b1, 32'd1032,   32'hDEADBEEF, 18'h00004, 32'h00000000};
      vecs[1]  = '{1'b1, 1'b0, 32'd1032,   32'hFFFF0000, 18'h00004, 32'hDEADBEEF};
      vecs[2]  = '{1'b1, 1'b1, 32'd1040,   32'h12345678, 18'h00008, 32'hDEADBEEF};
      vecs[3]  = '{1'b1, 1'b0, 32'd1040,   32'hFFFF0000, 18'h00008, 32'h12345678};
      vecs[4]  = '{1'b0, 1'b1, 32'd525308, 32'hCAFEF00D, 18'h3FFFE, 32'h12345678};
      vecs[5]  = '{1'b1, 1'b0, 32'd525308, 32'hFFFF0000, 18'h3FFFE, 32'hCAFEF00D};
      vecs[6]  = '{1'b0, 1'b1, 32'd525312, 32'hA5A55A5A, 18'h00000, 32'hCAFEF00D};
      vecs[7]  = '{1'b1, 1'b0, 32'd525312, 32'hFFFF0000, 18'h00000, 32'hA5A55A5A};
      vecs[8]  = '{1'b0, 1'b1, 32'd1020,   32'h0BADC0DE, 18'h3FFFE, 32'hA5A55A5A};
      vecs[9]  = '{1'b1, 1'b0, 32'd525308, 32'hFFFF0000, 18'h3FFFE, 32'h0BADC0DE};
      vecs[10] = '{1'b1, 1'b0, 32'd1032,   32'hFFFF0000, 18'h00004, 32'hDEADBEEF};

      rst        = 1'b0;
      Mem_R_en   = 1'b0;
      Mem_W_en   = 1'b0;
      ALU_result = '0;
      Val_Rm     = '0;
      #3;
      chk("rst_rv", Mem_read_value, 32'd0);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_we_n", 32'(SRAM_WE_N), 32'd1);
      chk("rst_oe", 32'(SRAM_DQ_oe), 32'd0);
      chk("rst_addr", 32'(SRAM_ADDR), 32'd0);
      chk("rst_dq", 32'(SRAM_DQ_out), 32'd0);
      Mem_R_en = 1'b1;
      #1;
      chk("rst_ready_req", 32'(ready), 32'd0);
      Mem_R_en = 1'b0;
      #8 rst = 1'b1;
      @(posedge clk); #1;

      idle(10);

      for (int i = 0; i < 11; i++) begin
         access(vecs[i]);
         if (i % 3 == 2) idle(1);
      end
      idle(1);

      // Reset during the high-half write of a store.
      Mem_W_en   = 1'b1;
      ALU_result = 32'd1048;
      Val_Rm     = 32'h11112222;
      for (int cyc = 0; cyc <= 3; cyc++) begin
         @(negedge clk);
         if (cyc < 3) begin
            @(posedge clk); #1;
         end
      end
      chk("mid_we_n_pre", 32'(SRAM_WE_N), 32'd0);
      chk("mid_addr_pre", 32'(SRAM_ADDR), 32'd13);
      #1 rst = 1'b0;
      #1;
      chk("mid_we_n", 32'(SRAM_WE_N), 32'd1);
      chk("mid_oe", 32'(SRAM_DQ_oe), 32'd0);
      chk("mid_addr", 32'(SRAM_ADDR), 32'd0);
      chk("mid_ready_req", 32'(ready), 32'd0);
      Mem_W_en = 1'b0;
      #1;
      chk("mid_ready", 32'(ready), 32'd1);
      chk("mid_rv", Mem_read_value, 32'd0);
      chk("mid_partial_lo", 32'(mem[12]), 32'h2222);
      rst = 1'b1;
      @(posedge clk); #1;
      idle(2);
      rv_vec = '{1'b1, 1'b0, 32'd1032, 32'h0, 18'h00004, 32'hDEADBEEF};
      access(rv_vec);
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
